// File: rtl/decoder_pio_arbiter.sv
`timescale 1ns/1ps
// Round-robin Avalon-MM master sharing the 8-bit decoder PIO between two requesters.
// A shadow of the PIO direction register suppresses redundant direction writes.
module decoder_pio_arbiter #(
    parameter int                DATA_W  = 8,
    parameter logic [DATA_W-1:0] RST_DIR = 8'h00
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              req0_valid,
    input  logic              req0_write,
    input  logic [DATA_W-1:0] req0_dir,
    input  logic [DATA_W-1:0] req0_wdata,
    output logic              req0_ready,
    output logic              req0_rvalid,
    output logic [DATA_W-1:0] req0_rdata,
    input  logic              req1_valid,
    input  logic              req1_write,
    input  logic [DATA_W-1:0] req1_dir,
    input  logic [DATA_W-1:0] req1_wdata,
    output logic              req1_ready,
    output logic              req1_rvalid,
    output logic [DATA_W-1:0] req1_rdata,
    output logic [1:0]        avm_address,
    output logic              avm_chipselect,
    output logic              avm_write_n,
    output logic [31:0]       avm_writedata,
    input  logic [31:0]       avm_readdata
);

    typedef enum logic [2:0] {IDLE, DIR_WR, DATA_WR, RD_ADDR, RD_CAP} state_t;

    state_t            state_q, state_d;
    logic [DATA_W-1:0] shadow_dir_q, shadow_dir_d;
    logic              last_grant_q, last_grant_d;
    logic              cap_write_q;
    logic [DATA_W-1:0] cap_dir_q, cap_wdata_q;
    logic              rvalid0_q, rvalid1_q;
    logic [DATA_W-1:0] rdata0_q, rdata1_q;

    logic              grant_id, accept, sel_write;
    logic [DATA_W-1:0] sel_dir, sel_wdata;
    logic              unused_rd_hi;

    assign unused_rd_hi = ^avm_readdata[31:DATA_W];

    // On a tie the requester that did not win last time is granted.
    always_comb begin
        grant_id  = (req0_valid && req1_valid) ? ~last_grant_q : req1_valid;
        accept    = (state_q == IDLE) && (req0_valid || req1_valid);
        sel_write = grant_id ? req1_write : req0_write;
        sel_dir   = grant_id ? req1_dir   : req0_dir;
        sel_wdata = grant_id ? req1_wdata : req0_wdata;
    end

    assign req0_ready  = accept && !grant_id;
    assign req1_ready  = accept && grant_id;
    assign req0_rvalid = rvalid0_q;
    assign req1_rvalid = rvalid1_q;
    assign req0_rdata  = rdata0_q;
    assign req1_rdata  = rdata1_q;

    always_comb begin
        state_d        = state_q;
        shadow_dir_d   = shadow_dir_q;
        last_grant_d   = last_grant_q;
        avm_chipselect = 1'b0;
        avm_write_n    = 1'b1;
        avm_address    = 2'd0;
        avm_writedata  = '0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    last_grant_d = grant_id;
                    if (sel_dir != shadow_dir_q) state_d = DIR_WR;
                    else if (sel_write)          state_d = DATA_WR;
                    else                         state_d = RD_ADDR;
                end
            end
            DIR_WR: begin
                avm_chipselect = 1'b1;
                avm_write_n    = 1'b0;
                avm_address    = 2'd1;
                avm_writedata  = {{(32-DATA_W){1'b0}}, cap_dir_q};
                shadow_dir_d   = cap_dir_q;
                state_d        = cap_write_q ? DATA_WR : RD_ADDR;
            end
            DATA_WR: begin
                avm_chipselect = 1'b1;
                avm_write_n    = 1'b0;
                avm_writedata  = {{(32-DATA_W){1'b0}}, cap_wdata_q};
                state_d        = IDLE;
            end
            RD_ADDR: begin
                avm_chipselect = 1'b1;
                state_d        = RD_CAP;
            end
            RD_CAP:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // last_grant_q also identifies the owner of the sequence in flight.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            shadow_dir_q <= RST_DIR;
            last_grant_q <= 1'b1;
            rvalid0_q    <= 1'b0;
            rvalid1_q    <= 1'b0;
            rdata0_q     <= '0;
            rdata1_q     <= '0;
        end else begin
            state_q      <= state_d;
            shadow_dir_q <= shadow_dir_d;
            last_grant_q <= last_grant_d;
            rvalid0_q    <= (state_q == RD_CAP) && !last_grant_q;
            rvalid1_q    <= (state_q == RD_CAP) && last_grant_q;
            if (state_q == RD_CAP) begin
                if (last_grant_q) rdata1_q <= avm_readdata[DATA_W-1:0];
                else              rdata0_q <= avm_readdata[DATA_W-1:0];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            cap_write_q <= sel_write;
            cap_dir_q   <= sel_dir;
            cap_wdata_q <= sel_wdata;
        end
    end

endmodule

// File: tb/tb_decoder_pio_arbiter.sv
`timescale 1ns/1ps
// Bench for decoder_pio_arbiter: directed vector table, arbitration and reset sequences,
// then random traffic against a transaction-level model of the arbiter and PIO.
module tb_decoder_pio_arbiter;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        req0_valid, req0_write, req1_valid, req1_write;
    logic [7:0]  req0_dir, req0_wdata, req1_dir, req1_wdata;
    logic        req0_ready, req0_rvalid, req1_ready, req1_rvalid;
    logic [7:0]  req0_rdata, req1_rdata;
    logic [1:0]  avm_address;
    logic        avm_chipselect, avm_write_n;
    logic [31:0] avm_writedata, avm_readdata;

    always #5 clk = ~clk;

    decoder_pio_arbiter #(.DATA_W(8), .RST_DIR(8'h00)) dut (
        .clk(clk), .reset_n(reset_n),
        .req0_valid(req0_valid), .req0_write(req0_write), .req0_dir(req0_dir),
        .req0_wdata(req0_wdata), .req0_ready(req0_ready), .req0_rvalid(req0_rvalid),
        .req0_rdata(req0_rdata),
        .req1_valid(req1_valid), .req1_write(req1_write), .req1_dir(req1_dir),
        .req1_wdata(req1_wdata), .req1_ready(req1_ready), .req1_rvalid(req1_rvalid),
        .req1_rdata(req1_rdata),
        .avm_address(avm_address), .avm_chipselect(avm_chipselect),
        .avm_write_n(avm_write_n), .avm_writedata(avm_writedata),
        .avm_readdata(avm_readdata)
    );

    // PIO slave: data latch, direction register, registered readdata every clock.
    logic [7:0] ext_pins, pio_dir, pio_out, pin_state;
    assign pin_state = (pio_dir & pio_out) | (~pio_dir & ext_pins);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pio_dir      <= 8'h00;
            pio_out      <= 8'h00;
            avm_readdata <= 32'h0;
        end else begin
            if (avm_chipselect && !avm_write_n) begin
                if (avm_address == 2'd1)      pio_dir <= avm_writedata[7:0];
                else if (avm_address == 2'd0) pio_out <= avm_writedata[7:0];
            end
            avm_readdata <= (avm_address == 2'd1) ? {24'h0, pio_dir} : {24'h0, pin_state};
        end
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    logic [35:0] bus_now;
    assign bus_now = {avm_chipselect, avm_write_n, avm_address, avm_writedata};
    localparam logic [35:0] BUS_IDLE = {1'b0, 1'b1, 2'd0, 32'h0};

    logic [7:0] exp_rd [2];

    typedef struct {
        bit         id;
        bit         wr;
        logic [7:0] dir;
        logic [7:0] wdata;
        logic [7:0] pins;
        bit         dirwr;
        logic [7:0] rdata;
    } vec_t;

    vec_t vecs [8];

    // Called at posedge+1 with the DUT in IDLE; returns at posedge+1 with the DUT in IDLE.
    task automatic do_txn(input vec_t v);
        ext_pins = v.pins;
        if (v.id) begin
            req1_write = v.wr; req1_dir = v.dir; req1_wdata = v.wdata; req1_valid = 1'b1;
        end else begin
            req0_write = v.wr; req0_dir = v.dir; req0_wdata = v.wdata; req0_valid = 1'b1;
        end
        #1;
        check("txn_ready", 64'({req1_ready, req0_ready}), 64'(v.id ? 2'b10 : 2'b01));
        @(posedge clk); #1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        if (v.dirwr) begin
            check("txn_dir_wr", 64'(bus_now), 64'({1'b1, 1'b0, 2'd1, 24'h0, v.dir}));
            @(posedge clk); #1;
        end
        if (v.wr) begin
            check("txn_data_wr", 64'(bus_now), 64'({1'b1, 1'b0, 2'd0, 24'h0, v.wdata}));
            @(posedge clk); #1;
            check("txn_wr_idle", 64'({avm_chipselect, avm_write_n, avm_address}), 64'(4'b0100));
        end else begin
            check("txn_rd_addr", 64'({avm_chipselect, avm_write_n, avm_address}), 64'(4'b1100));
            @(posedge clk); #1;
            check("txn_rd_cap", 64'({avm_chipselect, req1_rvalid, req0_rvalid}), 64'(0));
            @(posedge clk); #1;
            exp_rd[v.id] = v.rdata;
            check("txn_rvalid", 64'({req1_rvalid, req0_rvalid}), 64'(v.id ? 2'b10 : 2'b01));
            check("txn_rdata0", 64'(req0_rdata), 64'(exp_rd[0]));
            check("txn_rdata1", 64'(req1_rdata), 64'(exp_rd[1]));
            @(posedge clk); #1;
            check("txn_rvalid_pulse", 64'({req1_rvalid, req0_rvalid}), 64'(0));
        end
    endtask

    // Random-phase model state.
    typedef struct {int cyc; bit id; bit wr; logic [1:0] addr; logic [7:0] data;} op_t;
    typedef struct {int cyc; bit id; logic [7:0] data;} rv_t;
    op_t        ops [$];
    rv_t        rvq [$];
    op_t        op;
    rv_t        rv;
    logic [7:0] m_dir, m_latch, m_shadow, adir, awd;
    logic [7:0] dirs [4];
    logic [1:0] exp_rv, exp_rdy;
    bit         m_last, v0, v1, g, awr;
    int         busy, k;

    initial begin
        reset_n = 1'b0;
        req0_valid = 1'b0; req0_write = 1'b0; req0_dir = 8'h00; req0_wdata = 8'h00;
        req1_valid = 1'b0; req1_write = 1'b0; req1_dir = 8'h00; req1_wdata = 8'h00;
        ext_pins = 8'h00;
        exp_rd[0] = 8'h00;
        exp_rd[1] = 8'h00;

        vecs[0] = '{1'b0, 1'b1, 8'hFF, 8'hA5, 8'h00, 1'b1, 8'h00};
        vecs[1] = '{1'b0, 1'b1, 8'hFF, 8'h3C, 8'h00, 1'b0, 8'h00};
        vecs[2] = '{1'b1, 1'b0, 8'h00, 8'h00, 8'h5A, 1'b1, 8'h5A};
        vecs[3] = '{1'b0, 1'b0, 8'h00, 8'h00, 8'hC3, 1'b0, 8'hC3};
        vecs[4] = '{1'b1, 1'b1, 8'h0F, 8'h96, 8'h00, 1'b1, 8'h00};
        vecs[5] = '{1'b0, 1'b0, 8'h0F, 8'h00, 8'hA0, 1'b0, 8'hA6};
        vecs[6] = '{1'b1, 1'b0, 8'hF0, 8'h00, 8'h05, 1'b1, 8'h95};
        vecs[7] = '{1'b1, 1'b1, 8'hF0, 8'h11, 8'h00, 1'b0, 8'h00};

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_bus", 64'(bus_now), 64'(BUS_IDLE));
        check("rst_rvalid", 64'({req1_rvalid, req0_rvalid}), 64'(0));
        check("rst_rdata", 64'({req1_rdata, req0_rdata}), 64'(0));
        check("rst_ready", 64'({req1_ready, req0_ready}), 64'(0));
        reset_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 8; i++) do_txn(vecs[i]);

        // Both requesters valid every cycle with matching direction: grants alternate.
        req0_write = 1'b1; req0_dir = 8'hF0; req0_wdata = 8'h10; req0_valid = 1'b1;
        req1_write = 1'b1; req1_dir = 8'hF0; req1_wdata = 8'h20; req1_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            #1;
            if (i % 2 == 0) begin
                check("rr_grant", 64'({req1_ready, req0_ready}),
                      64'(((i / 2) % 2 == 0) ? 2'b01 : 2'b10));
            end else begin
                check("rr_busy", 64'({req1_ready, req0_ready}), 64'(0));
                check("rr_bus_wr", 64'(bus_now),
                      64'({1'b1, 1'b0, 2'd0, 24'h0, (((i - 1) / 2) % 2 == 0) ? 8'h10 : 8'h20}));
            end
            @(posedge clk); #1;
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;

        // Reset during the direction write of a read aborts it.
        req0_write = 1'b0; req0_dir = 8'h00; req0_valid = 1'b1;
        #1;
        check("abort_ready", 64'({req1_ready, req0_ready}), 64'(2'b01));
        @(posedge clk); #1;
        req0_valid = 1'b0;
        check("abort_dir_wr", 64'(bus_now), 64'({1'b1, 1'b0, 2'd1, 32'h0}));
        #1 reset_n = 1'b0;
        #1;
        exp_rd[0] = 8'h00;
        exp_rd[1] = 8'h00;
        check("abort_bus_idle", 64'(bus_now), 64'(BUS_IDLE));
        check("abort_rdata", 64'({req1_rdata, req0_rdata}), 64'(0));
        @(posedge clk); #1;
        check("abort_bus_hold", 64'(bus_now), 64'(BUS_IDLE));
        reset_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            check("abort_no_rvalid", 64'({req1_rvalid, req0_rvalid}), 64'(0));
            check("abort_cs", 64'(avm_chipselect), 64'(0));
        end
        // First tie after reset goes to requester 0; requester 1 withdraws unserved.
        req1_write = 1'b1; req1_dir = 8'h00; req1_wdata = 8'h55; req1_valid = 1'b1;
        do_txn('{1'b0, 1'b0, 8'h00, 8'h00, 8'h77, 1'b0, 8'h77});

        // Random traffic against a transaction-level model.
        dirs[0] = 8'h00; dirs[1] = 8'hFF; dirs[2] = 8'h0F; dirs[3] = 8'hF0;
        m_dir = 8'h00; m_latch = 8'h00; m_shadow = 8'h00; m_last = 1'b0; busy = 0;
        for (int s = 0; s < 400; s++) begin
            ext_pins = 8'($urandom);
            if (ops.size() > 0 && ops[0].cyc == s) begin
                op = ops.pop_front();
                if (op.wr) begin
                    check("rnd_bus_wr", 64'(bus_now), 64'({1'b1, 1'b0, op.addr, 24'h0, op.data}));
                    if (op.addr == 2'd1) m_dir = op.data;
                    else                 m_latch = op.data;
                end else begin
                    check("rnd_bus_rd", 64'({avm_chipselect, avm_write_n, avm_address}),
                          64'(4'b1100));
                    rvq.push_back('{s + 2, op.id, (m_dir & m_latch) | (~m_dir & ext_pins)});
                end
            end else begin
                check("rnd_bus_idle", 64'({avm_chipselect, avm_write_n, avm_address}),
                      64'(4'b0100));
            end
            exp_rv = 2'b00;
            if (rvq.size() > 0 && rvq[0].cyc == s) begin
                rv = rvq.pop_front();
                exp_rv = rv.id ? 2'b10 : 2'b01;
                exp_rd[rv.id] = rv.data;
            end
            check("rnd_rvalid", 64'({req1_rvalid, req0_rvalid}), 64'(exp_rv));
            check("rnd_rdata0", 64'(req0_rdata), 64'(exp_rd[0]));
            check("rnd_rdata1", 64'(req1_rdata), 64'(exp_rd[1]));

            v0 = (s < 390) && ($urandom_range(0, 2) != 0);
            v1 = (s < 390) && ($urandom_range(0, 2) != 0);
            req0_valid = v0; req0_write = 1'($urandom);
            req0_dir = dirs[$urandom_range(0, 3)]; req0_wdata = 8'($urandom);
            req1_valid = v1; req1_write = 1'($urandom);
            req1_dir = dirs[$urandom_range(0, 3)]; req1_wdata = 8'($urandom);
            #1;
            exp_rdy = 2'b00;
            if (busy == 0 && (v0 || v1)) begin
                g = (v0 && v1) ? !m_last : v1;
                exp_rdy = g ? 2'b10 : 2'b01;
                m_last = g;
                awr  = g ? req1_write : req0_write;
                adir = g ? req1_dir   : req0_dir;
                awd  = g ? req1_wdata : req0_wdata;
                k = 1;
                if (adir != m_shadow) begin
                    ops.push_back('{s + 1, g, 1'b1, 2'd1, adir});
                    m_shadow = adir;
                    k = 2;
                end
                ops.push_back('{s + k, g, awr, 2'd0, awd});
                busy = k + (awr ? 0 : 1);
            end else if (busy > 0) begin
                busy--;
            end
            check("rnd_ready", 64'({req1_ready, req0_ready}), 64'(exp_rdy));
            @(posedge clk); #1;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/decoder_pio_arbiter.md
Name: decoder_pio_arbiter

Overview:
- Avalon-MM master that shares the 8-bit bidirectional decoder PIO slave between two requesters.
- Register map of the PIO slave: address 0 = data (write sets output latch, read returns pin state); address 1 = direction (1 = drive).
- The PIO slave's readdata is registered on every clock.
- Arbitrates round-robin, keeps a shadow of the direction register, and emits a direction write only when the granted request needs a different direction.
- Sequences each data write or pin read.

Parameters:
- DATA_W, 8, PIO data/direction width; fixed at 8 in this revision.
- RST_DIR, 8'h00, shadow direction value after reset; must equal the PIO slave's direction reset value.

Ports:
- clk  in  1  clock
- reset_n  in  1  reset; asynchronous, active-low
- req0_valid  in  1  requester 0 has a request
- req0_write  in  1  1 = data write, 0 = pin read
- req0_dir  in  8  direction the request needs
- req0_wdata  in  8  data for a write
- req0_ready  out  1  request accepted this cycle
- req0_rvalid  out  1  read result valid (1-cycle pulse)
- req0_rdata  out  8  read result
- req1_valid, req1_write, req1_dir, req1_wdata, req1_ready, req1_rvalid, req1_rdata: same as requester 0
- avm_address  out  2  PIO slave address
- avm_chipselect  out  1  PIO slave select
- avm_write_n  out  1  PIO write strobe, active-low
- avm_writedata  out  32  {24'b0, byte}
- avm_readdata  in  32  PIO registered readdata; only bits [7:0] are used

Behaviour:
- Reset (asynchronous, any state):
  - FSM goes to IDLE; shadow_dir = RST_DIR; last_grant = 1, so requester 0 wins the first tie.
  - All ready/rvalid = 0; rdata = 0.
  - avm_chipselect = 0, avm_write_n = 1, avm_address = 0, avm_writedata = 0.
- FSM states: IDLE, DIR_WR, DATA_WR, RD_ADDR, RD_CAP.
- IDLE:
  - grant = the only valid requester; if both are valid, grant = !last_grant.
  - reqN_ready = (state == IDLE) && grant == N && reqN_valid. This is combinational, and at most one ready is high at a time.
  - On acceptance: capture write, dir and wdata; last_grant = N.
  - Next state: DIR_WR if captured dir != shadow_dir; otherwise DATA_WR (write) or RD_ADDR (read).
  - Bus idle: chipselect = 0, write_n = 1, address = 0.
- DIR_WR (one cycle): chipselect = 1, write_n = 0, address = 1, writedata = {24'b0, dir}; shadow_dir <= dir. Next state: DATA_WR or RD_ADDR.
- DATA_WR (one cycle): chipselect = 1, write_n = 0, address = 0, writedata = {24'b0, wdata}. Next state: IDLE. No response is returned to the requester.
- RD_ADDR (one cycle): chipselect = 1, write_n = 1, address = 0. The PIO registers pin state at the end of this cycle.
- RD_CAP (one cycle):
  - Bus idle, address held at 0.
  - reqN_rdata <= avm_readdata[7:0]; reqN_rvalid <= 1 (registered), so the pulse appears in the following cycle.
  - Next state: IDLE.
- Latency, with acceptance at cycle T:
  - write, direction match: bus write at T+1; IDLE at T+2.
  - write, direction change: dir write at T+1, data write at T+2; IDLE at T+3.
  - read, direction match: rvalid/rdata visible at T+3.
  - read, direction change: rvalid/rdata visible at T+4.
- rvalid is a single-cycle pulse. rdata holds its value until the next read for the same requester.
- A new request may be accepted in the same cycle that a previous read's rvalid is high.
- Requesters may drop valid before ready without effect. Fields are sampled only in the acceptance cycle.
- Exactly one bus write or read is performed per bus cycle; chipselect is never high in IDLE or RD_CAP.
- A reset mid-sequence aborts it:
  - Any pending rvalid is lost.
  - shadow_dir returns to RST_DIR; this matches the PIO slave, which resets too.

Test Plan:
- Reset, then req0 write (dir = 8'hFF, wdata = 8'hA5) -> DIR_WR to address 1 with 32'h000000FF at T+1, DATA_WR to address 0 with 32'h000000A5 at T+2, IDLE at T+3.
- A second req0 write, dir = 8'hFF, wdata = 8'h3C -> no direction write; a single write of 32'h0000003C at T+1.
- req1 read with dir = 8'h00 (after FF), external pins driven 8'h5A -> direction write of 0, RD_ADDR, then req1_rvalid pulses once with req1_rdata = 8'h5A at T+4; req0_rvalid stays 0.
- req0 and req1 valid every cycle, same dir -> grants alternate 0,1,0,1 starting with 0; ready is never high on both.
- Assert reset_n low during DIR_WR of a read -> bus immediately idle, no rvalid; after release, a read with dir = 8'h00 goes straight to RD_ADDR (no direction write).
